reg_file_param: RTL and testbench

//  Parametrised next-generation CPU register file: NREGS x DATA_W storage, 1 write / 2 read ports,

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_if.sv | 46 ++++
 rtl/reg_file_dump_ctrl.sv | 70 +++++++
 rtl/reg_file_param.sv | 86 ++++++++
 tb/tb_reg_file_param.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared types for the parametrised register file.
// Dump FSM encodings and register-count derivation.
package reg_file_pkg;

  typedef enum logic {
    RF_IDLE = 1'b0,
    RF_SCAN = 1'b1
  } rf_state_e;

  function automatic int nregs(int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: write, two reads, pending scoreboard and the
// serial dump handshake.
interface reg_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr1, rd_addr2,
    output pend_set, pend_addr,
    output dump_start, dump_ready,
    input  rd_data1, rd_data2,
    input  rd_busy1, rd_busy2,
    input  dump_busy, dump_valid,
    input  dump_addr, dump_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr1, rd_addr2,
    input  pend_set, pend_addr,
    input  dump_start, dump_ready,
    output rd_data1, rd_data2,
    output rd_busy1, rd_busy2,
    output dump_busy, dump_valid,
    output dump_addr, dump_data
  );
endinterface

// File: rtl/reg_file_dump_ctrl.sv
// Serial dump engine: walks every register once, one beat per
// valid/ready handshake, from a registered snapshot.
module reg_file_dump_ctrl
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_nxt [NREGS],
  output logic              o_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] w_idx_inc;
  logic              w_last;
  logic              w_fire;
  logic              w_go;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_last    = (r_idx == ADDR_W'(NREGS - 1));
  assign w_fire    = (r_state == RF_SCAN) && i_ready;
  assign w_go      = (r_state == RF_IDLE) && i_start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RF_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RF_IDLE: if (i_start) w_state_nxt = RF_SCAN;
      RF_SCAN: if (w_fire && w_last) w_state_nxt = RF_IDLE;
      default: w_state_nxt = RF_IDLE;
    endcase
  end

  // i_nxt already reflects a write landing on this same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (w_go) begin
      r_idx  <= '0;
      r_data <= i_nxt[0];
    end else if (w_fire && !w_last) begin
      r_idx  <= w_idx_inc;
      r_data <= i_nxt[w_idx_inc];
    end
  end

  always_comb begin
    o_valid = (r_state == RF_SCAN);
    o_busy  = (r_state == RF_SCAN);
    o_addr  = r_idx;
    o_data  = r_data;
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 1W/2R register file with bypass, optional zero
// register, pending scoreboard and serial debug dump.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic   clk,
  input  logic   rst,
  reg_file_if.slave bus
);

  localparam int NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] w_nxt  [NREGS];
  logic [NREGS-1:0]  r_pend;
  logic              w_wr;
  logic              w_pset;

  // R0 swallows writes and pend marks when hardwired
  assign w_wr   = bus.wr_en &&
                  !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign w_pset = bus.pend_set &&
                  !((ZERO_REG != 0) && (bus.pend_addr == '0));

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_nxt[i] = r_regs[i];
      if (w_wr && (bus.wr_addr == ADDR_W'(i)))
        w_nxt[i] = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= w_nxt[i];
        if (w_pset && (bus.pend_addr == ADDR_W'(i)))
          r_pend[i] <= 1'b1;
        else if (w_wr && (bus.wr_addr == ADDR_W'(i)))
          r_pend[i] <= 1'b0;
      end
    end
  end

  function automatic logic [DATA_W:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W:0] r;
    r = {r_pend[a], r_regs[a]};
    if ((ZERO_REG != 0) && (a == '0))
      r = '0;
    else if ((BYPASS != 0) && w_wr && (bus.wr_addr == a))
      r = {1'b0, bus.wr_data};
    return r;
  endfunction

  always_comb begin
    {bus.rd_busy1, bus.rd_data1} = rd_port(bus.rd_addr1);
    {bus.rd_busy2, bus.rd_data2} = rd_port(bus.rd_addr2);
  end

  reg_file_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_dump (
    .clk     (clk),
    .rst     (rst),
    .i_start (bus.dump_start),
    .i_ready (bus.dump_ready),
    .i_nxt   (w_nxt),
    .o_valid (bus.dump_valid),
    .o_busy  (bus.dump_busy),
    .o_addr  (bus.dump_addr),
    .o_data  (bus.dump_data)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two configurations driven in lockstep
// and compared against a behavioural model every cycle.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, pend_set, dump_start, dump_ready;
  logic [2:0] wr_addr, rd_addr1, rd_addr2, pend_addr;
  logic [7:0] wr_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(8), .ADDR_W(3)) ifa ();
  reg_file_if #(.DATA_W(8), .ADDR_W(3)) ifb ();

  assign ifa.wr_en = wr_en;         assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr;     assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data;     assign ifb.wr_data = wr_data;
  assign ifa.rd_addr1 = rd_addr1;   assign ifb.rd_addr1 = rd_addr1;
  assign ifa.rd_addr2 = rd_addr2;   assign ifb.rd_addr2 = rd_addr2;
  assign ifa.pend_set = pend_set;   assign ifb.pend_set = pend_set;
  assign ifa.pend_addr = pend_addr; assign ifb.pend_addr = pend_addr;
  assign ifa.dump_start = dump_start;
  assign ifb.dump_start = dump_start;
  assign ifa.dump_ready = dump_ready;
  assign ifb.dump_ready = dump_ready;

  reg_file_param #(
    .DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  reg_file_param #(
    .DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0] o_rd1 [2], o_rd2 [2], o_dd [2];
  logic       o_b1 [2], o_b2 [2], o_dv [2], o_db [2];
  logic [2:0] o_da [2];

  assign o_rd1[0] = ifa.rd_data1;   assign o_rd1[1] = ifb.rd_data1;
  assign o_rd2[0] = ifa.rd_data2;   assign o_rd2[1] = ifb.rd_data2;
  assign o_b1[0] = ifa.rd_busy1;    assign o_b1[1] = ifb.rd_busy1;
  assign o_b2[0] = ifa.rd_busy2;    assign o_b2[1] = ifb.rd_busy2;
  assign o_dv[0] = ifa.dump_valid;  assign o_dv[1] = ifb.dump_valid;
  assign o_db[0] = ifa.dump_busy;   assign o_db[1] = ifb.dump_busy;
  assign o_da[0] = ifa.dump_addr;   assign o_da[1] = ifb.dump_addr;
  assign o_dd[0] = ifa.dump_data;   assign o_dd[1] = ifb.dump_data;

  // model: index 0 = bypass, no zero reg; 1 = zero reg, no bypass
  bit         zr [2] = '{1'b0, 1'b1};
  bit         bp [2] = '{1'b1, 1'b0};
  logic [7:0] m_reg [2][8];
  bit         m_pend [2][8];
  bit         m_act [2];
  int         m_idx [2];
  logic [7:0] m_dd [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_ok(int c);
    return wr_en && !(zr[c] && wr_addr == 3'd0);
  endfunction

  function automatic bit pset_ok(int c);
    return pend_set && !(zr[c] && pend_addr == 3'd0);
  endfunction

  task automatic rd_exp(input int c, input logic [2:0] a,
                        output logic [7:0] d, output logic b);
    if (zr[c] && a == 3'd0) begin
      d = 8'h00; b = 1'b0;
    end else if (bp[c] && wr_ok(c) && wr_addr == a) begin
      d = wr_data; b = 1'b0;
    end else begin
      d = m_reg[c][a]; b = m_pend[c][a];
    end
  endtask

  task automatic model_update();
    logic [7:0] nr [8];
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_reg[c][i] = 8'h00; m_pend[c][i] = 1'b0;
        end
        m_act[c] = 1'b0; m_idx[c] = 0; m_dd[c] = 8'h00;
      end else begin
        nr = m_reg[c];
        if (wr_ok(c)) begin
          nr[wr_addr] = wr_data;
          m_pend[c][wr_addr] = 1'b0;
        end
        if (pset_ok(c)) m_pend[c][pend_addr] = 1'b1;
        if (!m_act[c]) begin
          if (dump_start) begin
            m_act[c] = 1'b1; m_idx[c] = 0; m_dd[c] = nr[0];
          end
        end else if (dump_ready) begin
          if (m_idx[c] == 7) m_act[c] = 1'b0;
          else begin
            m_idx[c]++; m_dd[c] = nr[m_idx[c]];
          end
        end
        m_reg[c] = nr;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] d;
    logic       b;
    for (int c = 0; c < 2; c++) begin
      rd_exp(c, rd_addr1, d, b);
      chk($sformatf("c%0d rd1[%0d]", c, rd_addr1), 32'(o_rd1[c]), 32'(d));
      chk($sformatf("c%0d busy1", c), 32'(o_b1[c]), 32'(b));
      rd_exp(c, rd_addr2, d, b);
      chk($sformatf("c%0d rd2[%0d]", c, rd_addr2), 32'(o_rd2[c]), 32'(d));
      chk($sformatf("c%0d busy2", c), 32'(o_b2[c]), 32'(b));
      chk($sformatf("c%0d dvalid", c), 32'(o_dv[c]), 32'(m_act[c]));
      chk($sformatf("c%0d dbusy", c), 32'(o_db[c]), 32'(m_act[c]));
      if (m_act[c]) begin
        chk($sformatf("c%0d daddr", c), 32'(o_da[c]), 32'(m_idx[c]));
        chk($sformatf("c%0d ddata", c), 32'(o_dd[c]), 32'(m_dd[c]));
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    check_all();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    half();
    edge_();
  endtask

  task automatic quiet();
    rst = 0; wr_en = 0; pend_set = 0; dump_start = 0; dump_ready = 0;
    wr_addr = 0; wr_data = 0; pend_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  logic [2:0] b_addr [$];
  logic [7:0] b_data [$];
  int         cyc;

  initial begin
    quiet();
    rst = 1;
    @(posedge clk); model_update(); #1;
    tick();
    rst = 0;

    // reset state across all addresses
    for (int a = 0; a < 8; a += 2) begin
      rd_addr1 = 3'(a); rd_addr2 = 3'(a + 1);
      half();
      chk("rst rd1", 32'(ifa.rd_data1), 32'h0);
      chk("rst busy2", 32'(ifa.rd_busy2), 32'h0);
      chk("rst dvalid", 32'(ifa.dump_valid), 32'h0);
      edge_();
    end

    // write then read, and same-cycle bypass
    wr_en = 1; wr_addr = 3; wr_data = 8'hA5; tick();
    wr_en = 0; rd_addr1 = 3; half();
    chk("r3 a", 32'(ifa.rd_data1), 32'hA5);
    chk("r3 b", 32'(ifb.rd_data1), 32'hA5);
    edge_();
    wr_en = 1; wr_addr = 5; wr_data = 8'h3C; rd_addr2 = 5; half();
    chk("byp a", 32'(ifa.rd_data2), 32'h3C);
    chk("byp b", 32'(ifb.rd_data2), 32'h00);
    edge_();

    // zero register
    wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
    pend_set = 1; pend_addr = 0; tick();
    quiet(); half();
    chk("r0 b data", 32'(ifb.rd_data1), 32'h0);
    chk("r0 b busy", 32'(ifb.rd_busy1), 32'h0);
    chk("r0 a data", 32'(ifa.rd_data1), 32'hFF);
    chk("r0 a busy", 32'(ifa.rd_busy1), 32'h1);
    edge_();

    // pending scoreboard
    pend_set = 1; pend_addr = 2; tick();
    pend_set = 0; rd_addr1 = 2; half();
    chk("pend a", 32'(ifa.rd_busy1), 32'h1);
    edge_();
    wr_en = 1; wr_addr = 2; wr_data = 8'h11; tick();
    wr_en = 0; half();
    chk("clr busy", 32'(ifb.rd_busy1), 32'h0);
    edge_();
    wr_en = 1; pend_set = 1; pend_addr = 2; tick();
    quiet(); rd_addr1 = 2; half();
    chk("set wins busy", 32'(ifa.rd_busy1), 32'h1);
    chk("set wins data", 32'(ifa.rd_data1), 32'h11);
    edge_();

    // full dump with ready toggling
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_addr = 3'(k); wr_data = 8'(k + 1); tick();
    end
    quiet(); dump_start = 1; tick();
    dump_start = 0;
    cyc = 0;
    while (cyc < 64 && b_addr.size() < 8) begin
      dump_ready = (cyc % 2 == 0);
      half();
      if (ifa.dump_valid && dump_ready) begin
        b_addr.push_back(ifa.dump_addr);
        b_data.push_back(ifa.dump_data);
      end
      edge_();
      cyc++;
    end
    chk("beats", b_addr.size(), 8);
    for (int i = 0; i < b_addr.size(); i++) begin
      chk("beat addr", 32'(b_addr[i]), 32'(i));
      chk("beat data", 32'(b_data[i]), 32'(i + 1));
    end
    dump_ready = 0; half();
    chk("dump done", 32'(ifa.dump_busy), 32'h0);
    edge_();

    // reset during beat 4
    dump_start = 1; tick();
    dump_start = 0; dump_ready = 1;
    cyc = 0;
    half();
    while (cyc < 32 && ifa.dump_addr != 3'd4) begin
      edge_(); half(); cyc++;
    end
    chk("reach beat4", 32'(ifa.dump_addr), 32'h4);
    rst = 1; edge_();
    rst = 0; dump_ready = 0; rd_addr1 = 7; half();
    chk("rst dvalid", 32'(ifa.dump_valid), 32'h0);
    chk("rst dbusy", 32'(ifa.dump_busy), 32'h0);
    chk("rst r7", 32'(ifa.rd_data1), 32'h0);
    edge_();
    dump_start = 1; tick();
    dump_start = 0; half();
    chk("restart addr", 32'(ifa.dump_addr), 32'h0);
    chk("restart valid", 32'(ifa.dump_valid), 32'h1);
    edge_();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom % 80) == 0;
      wr_en      = $urandom % 2;
      wr_addr    = 3'($urandom);
      wr_data    = 8'($urandom);
      rd_addr1   = 3'($urandom);
      rd_addr2   = ($urandom % 3 == 0) ? wr_addr : 3'($urandom);
      pend_set   = ($urandom % 4) == 0;
      pend_addr  = ($urandom % 3 == 0) ? wr_addr : 3'($urandom);
      dump_start = ($urandom % 12) == 0;
      dump_ready = ($urandom % 3) != 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
